// File: rtl/inter_xbar_if.sv
// inter_xbar_if -- bundle of every master-side and slave-side bus signal of the
// inter_xbar crossbar.
//
// Signals (per-port arrays are packed, index = port number):
//   master_data_{addr,wdata,be,req,we}_i  requests from the masters
//   master_data_gnt_o                     request accepted this cycle
//   master_data_rvalid_o/rdata_o/err_o    responses to the masters
//   slave_data_{addr,wdata,be,req,we}_o   requests forwarded to the slaves
//   slave_data_gnt_i/rvalid_i/rdata_i     slave handshake and read data
//
// Modports:
//   xbar   - the crossbar itself
//   master - the initiator side (cores, DMA)
//   slave  - the target side (memories, peripherals)
interface inter_xbar_if #(
   parameter int DATA_WIDTH        = 32,
   parameter int MASTER_ADDR_WIDTH = 12,
   parameter int SLAVE_ADDR_WIDTH  = 10,
   parameter int MASTERS           = 4,
   parameter int SLAVES            = 3
);
   logic [MASTERS-1:0][MASTER_ADDR_WIDTH-1:0] master_data_addr_i;
   logic [MASTERS-1:0][DATA_WIDTH-1:0]        master_data_wdata_i;
   logic [MASTERS-1:0][DATA_WIDTH/8-1:0]      master_data_be_i;
   logic [MASTERS-1:0]                        master_data_req_i;
   logic [MASTERS-1:0]                        master_data_we_i;
   logic [MASTERS-1:0]                        master_data_gnt_o;
   logic [MASTERS-1:0]                        master_data_rvalid_o;
   logic [MASTERS-1:0][DATA_WIDTH-1:0]        master_data_rdata_o;
   logic [MASTERS-1:0]                        master_data_err_o;

   logic [SLAVES-1:0][SLAVE_ADDR_WIDTH-1:0]   slave_data_addr_o;
   logic [SLAVES-1:0][DATA_WIDTH-1:0]         slave_data_wdata_o;
   logic [SLAVES-1:0][DATA_WIDTH/8-1:0]       slave_data_be_o;
   logic [SLAVES-1:0]                         slave_data_req_o;
   logic [SLAVES-1:0]                         slave_data_we_o;
   logic [SLAVES-1:0]                         slave_data_gnt_i;
   logic [SLAVES-1:0]                         slave_data_rvalid_i;
   logic [SLAVES-1:0][DATA_WIDTH-1:0]         slave_data_rdata_i;

   modport xbar (
      input  master_data_addr_i, master_data_wdata_i, master_data_be_i,
             master_data_req_i, master_data_we_i,
      output master_data_gnt_o, master_data_rvalid_o, master_data_rdata_o,
             master_data_err_o,
      output slave_data_addr_o, slave_data_wdata_o, slave_data_be_o,
             slave_data_req_o, slave_data_we_o,
      input  slave_data_gnt_i, slave_data_rvalid_i, slave_data_rdata_i
   );

   modport master (
      output master_data_addr_i, master_data_wdata_i, master_data_be_i,
             master_data_req_i, master_data_we_i,
      input  master_data_gnt_o, master_data_rvalid_o, master_data_rdata_o,
             master_data_err_o
   );

   modport slave (
      input  slave_data_addr_o, slave_data_wdata_o, slave_data_be_o,
             slave_data_req_o, slave_data_we_o,
      output slave_data_gnt_i, slave_data_rvalid_i, slave_data_rdata_i
   );
endinterface

// File: rtl/inter_xbar.sv
// inter_xbar -- pipelined MASTERS x SLAVES data crossbar.
//
// Each slave has a round-robin arbiter and a FIFO recording which master owns
// each in-flight transaction, so a master may keep up to MAX_OUTSTANDING
// requests in flight to one slave. Request and response paths are purely
// combinational; only the bookkeeping (counts, last targets, pointers, FIFOs)
// is registered.
//
// Ports:
//   clk     clock
//   resetn  asynchronous active-low reset
//   bus     inter_xbar_if.xbar -- all master and slave bus signals
//
// Build option: define INTER_DECODE_ERR_EN to answer decode misses with a
// one-cycle error response; otherwise a decode miss is never granted and
// master_data_err_o is tied to 0.
module inter_xbar #(
   parameter int DATA_WIDTH        = 32,
   parameter int MASTER_ADDR_WIDTH = 12,
   parameter int SLAVE_ADDR_WIDTH  = 10,
   parameter int MASTERS           = 4,
   parameter int SLAVES            = 3,
   parameter int MAX_OUTSTANDING   = 4,
   parameter logic [SLAVES*MASTER_ADDR_WIDTH-1:0] SLAVE_ADDR_MATCH = {12'h800, 12'h400, 12'h000},
   parameter logic [SLAVES*MASTER_ADDR_WIDTH-1:0] SLAVE_ADDR_MASK  = {12'hC00, 12'hC00, 12'hC00}
) (
   input logic        clk,
   input logic        resetn,
   inter_xbar_if.xbar bus
);
   localparam int MW = (MASTERS > 1) ? $clog2(MASTERS) : 1;
   localparam int SW = $clog2(SLAVES + 1);
   localparam int CW = $clog2(MAX_OUTSTANDING + 1);
   localparam int FW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   // Target code one past the last slave marks "no slave" / error target.
   localparam logic [SW-1:0] ERR_TGT = SW'(SLAVES);
   localparam logic [CW-1:0] CNT_MAX = CW'(MAX_OUTSTANDING);

   logic [MASTERS-1:0][CW-1:0]                    cnt_q;
   logic [MASTERS-1:0][SW-1:0]                    last_q;
   logic [SLAVES-1:0][MW-1:0]                     ptr_q;
   logic [SLAVES-1:0][MAX_OUTSTANDING-1:0][MW-1:0] fifo_q;
   logic [SLAVES-1:0][FW-1:0]                     wr_q;
   logic [SLAVES-1:0][FW-1:0]                     rd_q;
   logic [SLAVES-1:0][CW-1:0]                     occ_q;

   logic [MASTERS-1:0][SW-1:0]      tgt;
   logic [MASTERS-1:0]              miss;
   logic [SLAVES-1:0][MASTERS-1:0]  sreq;
   logic [SLAVES-1:0]               any_win;
   logic [SLAVES-1:0][MW-1:0]       win;
   logic [SLAVES-1:0]               hs;
   logic [SLAVES-1:0]               pop;
   logic [MASTERS-1:0]              gnt_all;
   logic [MASTERS-1:0]              err_gnt;
   logic [MASTERS-1:0]              rsp;
`ifdef INTER_DECODE_ERR_EN
   logic [MASTERS-1:0]              err_q;
`endif

   function automatic logic [FW-1:0] fifo_next(input logic [FW-1:0] p);
      return (p == FW'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
   endfunction

   function automatic logic [MW-1:0] master_next(input logic [MW-1:0] m);
      return (m == MW'(MASTERS - 1)) ? '0 : m + 1'b1;
   endfunction

   // Address decode (lowest matching slave wins) and per-slave request vectors.
   always_comb begin
      tgt  = '0;
      miss = '0;
      sreq = '0;
      for (int m = 0; m < MASTERS; m++) begin
         tgt[m]  = ERR_TGT;
         miss[m] = 1'b1;
         for (int s = SLAVES - 1; s >= 0; s--) begin
            if ((bus.master_data_addr_i[m] & SLAVE_ADDR_MASK[s*MASTER_ADDR_WIDTH +: MASTER_ADDR_WIDTH])
                == SLAVE_ADDR_MATCH[s*MASTER_ADDR_WIDTH +: MASTER_ADDR_WIDTH]) begin
               tgt[m]  = SW'(s);
               miss[m] = 1'b0;
            end
         end
      end
      // A master may only stack requests on the slave it last used, which
      // keeps its responses in order without any reorder buffer.
      for (int s = 0; s < SLAVES; s++) begin
         for (int m = 0; m < MASTERS; m++) begin
            sreq[s][m] = bus.master_data_req_i[m] & ~miss[m] & (tgt[m] == SW'(s))
                         & (occ_q[s] != CNT_MAX)
                         & ((cnt_q[m] == '0) | ((last_q[m] == SW'(s)) & (cnt_q[m] < CNT_MAX)));
         end
      end
   end

   // Round-robin arbitration, slave request mux and master grants.
   always_comb begin
      int cand;
      cand    = 0;
      any_win = '0;
      win     = '0;
      hs      = '0;
      gnt_all = '0;
      err_gnt = '0;
      bus.slave_data_req_o   = '0;
      bus.slave_data_addr_o  = '0;
      bus.slave_data_wdata_o = '0;
      bus.slave_data_be_o    = '0;
      bus.slave_data_we_o    = '0;
      for (int s = 0; s < SLAVES; s++) begin
         for (int i = 0; i < MASTERS; i++) begin
            cand = int'(ptr_q[s]) + i;
            if (cand >= MASTERS) cand = cand - MASTERS;
            if (!any_win[s] && sreq[s][cand]) begin
               any_win[s] = 1'b1;
               win[s]     = MW'(cand);
            end
         end
         if (any_win[s]) begin
            bus.slave_data_req_o[s]   = 1'b1;
            bus.slave_data_addr_o[s]  = bus.master_data_addr_i[win[s]][SLAVE_ADDR_WIDTH-1:0];
            bus.slave_data_wdata_o[s] = bus.master_data_wdata_i[win[s]];
            bus.slave_data_be_o[s]    = bus.master_data_be_i[win[s]];
            bus.slave_data_we_o[s]    = bus.master_data_we_i[win[s]];
            hs[s] = bus.slave_data_gnt_i[s];
            if (hs[s]) gnt_all[win[s]] = 1'b1;
         end
      end
`ifdef INTER_DECODE_ERR_EN
      // A decode miss is accepted only from an idle master, so its error
      // response can never collide with a slave response.
      for (int m = 0; m < MASTERS; m++) begin
         err_gnt[m] = bus.master_data_req_i[m] & miss[m] & (cnt_q[m] == '0);
      end
`endif
      gnt_all = gnt_all | err_gnt;
      bus.master_data_gnt_o = gnt_all;
   end

   // Response routing: the FIFO head names the master owning each response.
   always_comb begin
      logic [MASTERS-1:0]                 rv;
      logic [MASTERS-1:0]                 er;
      logic [MASTERS-1:0][DATA_WIDTH-1:0] rd;
      logic [MW-1:0]                      head;
      rv   = '0;
      er   = '0;
      rd   = '0;
      head = '0;
      pop  = '0;
`ifdef INTER_DECODE_ERR_EN
      rv = err_q;
      er = err_q;
`endif
      for (int s = 0; s < SLAVES; s++) begin
         // A response with nothing outstanding (e.g. after reset) is ignored.
         if (bus.slave_data_rvalid_i[s] && (occ_q[s] != '0)) begin
            pop[s]   = 1'b1;
            head     = fifo_q[s][rd_q[s]];
            rv[head] = 1'b1;
            rd[head] = bus.slave_data_rdata_i[s];
         end
      end
      rsp = rv;
      bus.master_data_rvalid_o = rv;
      bus.master_data_rdata_o  = rd;
      bus.master_data_err_o    = er;
   end

   // Bookkeeping registers.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cnt_q  <= '0;
         last_q <= '0;
         ptr_q  <= '0;
         wr_q   <= '0;
         rd_q   <= '0;
         occ_q  <= '0;
      end else begin
         for (int m = 0; m < MASTERS; m++) begin
            cnt_q[m] <= cnt_q[m] + CW'(gnt_all[m]) - CW'(rsp[m]);
            if (gnt_all[m]) last_q[m] <= tgt[m];
         end
         for (int s = 0; s < SLAVES; s++) begin
            if (hs[s]) begin
               wr_q[s]  <= fifo_next(wr_q[s]);
               ptr_q[s] <= master_next(win[s]);
            end
            if (pop[s]) rd_q[s] <= fifo_next(rd_q[s]);
            occ_q[s] <= occ_q[s] + CW'(hs[s]) - CW'(pop[s]);
         end
      end
   end

   // FIFO storage needs no reset: occupancy alone decides what is valid.
   always_ff @(posedge clk) begin
      for (int s = 0; s < SLAVES; s++) begin
         if (hs[s]) fifo_q[s][wr_q[s]] <= win[s];
      end
   end

`ifdef INTER_DECODE_ERR_EN
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) err_q <= '0;
      else         err_q <= err_gnt;
   end
`endif
endmodule
